// File: rtl/acq_shift_pkg.sv
// Shared types, widths and the block-floating-point shift rule for the acquisition peak path.
// calc_shift returns the smallest shift whose biased-rounded peak still fits target_width bits.
package acq_shift_pkg;
    localparam int SHIFT_W = 4;
    localparam int DATA_W  = 10;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_CALC,
        ST_DRAIN
    } acq_state_e;

    function automatic logic [SHIFT_W-1:0] calc_shift(input logic [DATA_W-1:0] peak,
                                                       input int target_width);
        int   len;
        int   s0;
        int   sh;
        logic all_ones;
        len = 0;
        for (int i = 0; i < DATA_W; i++) begin
            if (peak[i]) len = i + 1;
        end
        s0 = (len > target_width) ? len - target_width : 0;
        sh = s0;
        if (s0 > 0) begin
            // Kept bits plus the rounding bit all set: rounding would carry out of the field.
            all_ones = 1'b1;
            for (int i = 0; i < DATA_W; i++) begin
                if (i >= s0 - 1 && i <= s0 + target_width - 1 && !peak[i]) all_ones = 1'b0;
            end
            if (all_ones) sh = s0 + 1;
        end
        if (sh > DATA_W) sh = DATA_W;
        return sh[SHIFT_W-1:0];
    endfunction
endpackage

// File: rtl/acq_frame_ram.sv
// Single-frame sample store: one write port, one synchronous read port with 1-cycle latency.
// The read register holds its value when no read is issued, so it doubles as the output register.
module acq_frame_ram
    import acq_shift_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/acq_peak_shift_ctrl.sv
// Buffers a frame, finds its peak, replays it with a fitting shift; first output 2 cycles after last input, outputs hold under stall.
// ACQ_PEAK_PINGPONG_EN: two banks so filling overlaps draining; otherwise input stalls from CALC until the frame drains.
module acq_peak_shift_ctrl
    import acq_shift_pkg::*;
#(
    parameter int FRAME_LEN    = 64,
    parameter int TARGET_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [SHIFT_W-1:0] shift_bit,
    output logic               out_last
);
    localparam int            AW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

    acq_state_e         state_q;
    logic [AW-1:0]      wr_cnt_q;
    logic [AW-1:0]      rd_cnt_q;
    logic [AW-1:0]      rd_cnt_d;
    logic [AW-1:0]      rd_addr;
    logic [SHIFT_W-1:0] shift_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic [DATA_W-1:0]  peak_d;
    logic               in_xfer;
    logic               out_xfer;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid_q & out_ready;
    assign rd_cnt_d  = rd_cnt_q + 1'b1;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign shift_bit = shift_q;

`ifdef ACQ_PEAK_PINGPONG_EN
    logic               wr_bank_q;
    logic               rd_bank_q;
    logic               nb;
    logic [1:0]         full_q;
    logic [DATA_W-1:0]  peak_q [2];
    logic [SHIFT_W-1:0] bank_shift_q [2];
    logic [DATA_W-1:0]  rd_data [2];
    logic [1:0]         rd_en;
    logic               fill_done;
    logic               rd_free;

    assign nb        = ~rd_bank_q;
    assign in_ready  = ~full_q[wr_bank_q];
    assign fill_done = in_xfer && (wr_cnt_q == LAST);
    assign peak_d    = (in_data > peak_q[wr_bank_q]) ? in_data : peak_q[wr_bank_q];
    assign out_data  = rd_data[rd_bank_q];
    // A bank is reusable once its last address has been read into the output register.
    assign rd_free   = (state_q == ST_DRAIN) && out_xfer && !out_last_q && (rd_cnt_d == LAST);

    always_comb begin
        rd_en   = '0;
        rd_addr = rd_cnt_d;
        if (state_q == ST_CALC) begin
            rd_en[rd_bank_q] = 1'b1;
            rd_addr          = '0;
        end else if (state_q == ST_DRAIN && out_xfer) begin
            if (!out_last_q) begin
                rd_en[rd_bank_q] = 1'b1;
            end else if (full_q[nb]) begin
                rd_en[nb] = 1'b1;
                rd_addr   = '0;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        acq_frame_ram #(.DEPTH(FRAME_LEN), .AW(AW)) u_ram (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (in_xfer && (wr_bank_q == 1'(b))),
            .wr_addr_i (wr_cnt_q),
            .wr_data_i (in_data),
            .rd_en_i   (rd_en[b]),
            .rd_addr_i (rd_addr),
            .rd_data_o (rd_data[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_FILL;
            wr_cnt_q        <= '0;
            rd_cnt_q        <= '0;
            wr_bank_q       <= 1'b0;
            rd_bank_q       <= 1'b0;
            full_q          <= '0;
            peak_q[0]       <= '0;
            peak_q[1]       <= '0;
            bank_shift_q[0] <= '0;
            bank_shift_q[1] <= '0;
            shift_q         <= '0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
        end else begin
            if (in_xfer) begin
                wr_cnt_q           <= wr_cnt_q + 1'b1;
                peak_q[wr_bank_q]  <= peak_d;
                if (wr_cnt_q == LAST) begin
                    full_q[wr_bank_q]       <= 1'b1;
                    bank_shift_q[wr_bank_q] <= calc_shift(peak_d, TARGET_WIDTH);
                    wr_bank_q               <= ~wr_bank_q;
                end
            end
            if (rd_free) begin
                full_q[rd_bank_q] <= 1'b0;
                peak_q[rd_bank_q] <= '0;
            end
            case (state_q)
                ST_FILL: begin
                    if (full_q[rd_bank_q] || (fill_done && wr_bank_q == rd_bank_q)) state_q <= ST_CALC;
                end
                ST_CALC: begin
                    shift_q     <= bank_shift_q[rd_bank_q];
                    out_valid_q <= 1'b1;
                    out_last_q  <= 1'b0;
                    rd_cnt_q    <= '0;
                    state_q     <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (out_xfer) begin
                        if (!out_last_q) begin
                            rd_cnt_q   <= rd_cnt_d;
                            out_last_q <= (rd_cnt_d == LAST);
                        end else begin
                            rd_bank_q  <= nb;
                            rd_cnt_q   <= '0;
                            out_last_q <= 1'b0;
                            if (full_q[nb]) begin
                                shift_q <= bank_shift_q[nb];
                            end else begin
                                out_valid_q <= 1'b0;
                                state_q     <= (fill_done && wr_bank_q == nb) ? ST_CALC : ST_FILL;
                            end
                        end
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end
`else
    logic [DATA_W-1:0] peak_q;
    logic              rd_en;

    assign in_ready = (state_q == ST_FILL);
    assign peak_d   = (in_data > peak_q) ? in_data : peak_q;
    assign rd_en    = (state_q == ST_CALC) || (state_q == ST_DRAIN && out_xfer && !out_last_q);
    assign rd_addr  = (state_q == ST_CALC) ? '0 : rd_cnt_d;

    acq_frame_ram #(.DEPTH(FRAME_LEN), .AW(AW)) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (in_xfer),
        .wr_addr_i (wr_cnt_q),
        .wr_data_i (in_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (out_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            peak_q      <= '0;
            shift_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (in_xfer) begin
                        wr_cnt_q <= wr_cnt_q + 1'b1;
                        peak_q   <= peak_d;
                        if (wr_cnt_q == LAST) state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    shift_q     <= calc_shift(peak_q, TARGET_WIDTH);
                    out_valid_q <= 1'b1;
                    out_last_q  <= 1'b0;
                    rd_cnt_q    <= '0;
                    state_q     <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (out_xfer) begin
                        if (!out_last_q) begin
                            rd_cnt_q   <= rd_cnt_d;
                            out_last_q <= (rd_cnt_d == LAST);
                        end else begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            peak_q      <= '0;
                            wr_cnt_q    <= '0;
                            rd_cnt_q    <= '0;
                            state_q     <= ST_FILL;
                        end
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end
`endif
endmodule
